osc_bank: RTL and testbench

OSC_BANK -- requirements
Module: osc_bank

---
 rtl/osc_bank_if.sv | 41 ++++
 rtl/osc_bank.sv | 177 +++++++++++++++++
 tb/tb_osc_bank.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osc_bank_if.sv
// rtl/osc_bank_if.sv - configuration request and sample stream bundle for osc_bank
//
// Signals:
//   Cfg_valid  master->slave  config request
//   Cfg_ready  slave->master  config accept (combinational)
//   Cfg_ch     master->slave  target channel
//   Cfg_init1  master->slave  start amplitude
//   Cfg_init2  master->slave  recurrence coefficient a
//   Cfg_defer  master->slave  1 = apply at next zero crossing
//   Cfg_stop   master->slave  stop the channel
//   Smp_valid  slave->master  registered sample strobe
//   Smp_ch     slave->master  channel of the sample
//   Smp_y      slave->master  sample value
interface osc_bank_if #(
    parameter int W   = 32,
    parameter int NCH = 4
);
    localparam int CW = $clog2(NCH);

    logic          Cfg_valid;
    logic          Cfg_ready;
    logic [CW-1:0] Cfg_ch;
    logic [W-1:0]  Cfg_init1;
    logic [W-1:0]  Cfg_init2;
    logic          Cfg_defer;
    logic          Cfg_stop;

    logic          Smp_valid;
    logic [CW-1:0] Smp_ch;
    logic [W-1:0]  Smp_y;

    modport master (
        output Cfg_valid, Cfg_ch, Cfg_init1, Cfg_init2, Cfg_defer, Cfg_stop,
        input  Cfg_ready, Smp_valid, Smp_ch, Smp_y
    );

    modport slave (
        input  Cfg_valid, Cfg_ch, Cfg_init1, Cfg_init2, Cfg_defer, Cfg_stop,
        output Cfg_ready, Smp_valid, Smp_ch, Smp_y
    );
endinterface

// File: rtl/osc_bank.sv
// rtl/osc_bank.sv - time-multiplexed bank of second-order recursive oscillators
//
// Ports:
//   Fg_clk   in   clock, all state on rising edge
//   Resetn   in   asynchronous active-low reset
//   Enable   in   advance channel pointer and compute one channel this cycle
//   bus      slave modport of osc_bank_if: config request, sample stream
//   Active   out  per-channel RUN or PEND
//   Pend     out  per-channel PEND (deferred reload waiting for zero crossing)
//
// Each channel iterates y[n] = a*y[n-1] - y[n-2] with a in Q(W-FRAC).FRAC.
// One channel is serviced per enabled cycle, round robin.
module osc_bank #(
    parameter int W    = 32,
    parameter int FRAC = 29,
    parameter int NCH  = 4,
    parameter int ZCB  = 10
) (
    input  logic           Fg_clk,
    input  logic           Resetn,
    input  logic           Enable,
    osc_bank_if.slave      bus,
    output logic [NCH-1:0] Active,
    output logic [NCH-1:0] Pend
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } ch_state_t;

    ch_state_t     st_q  [NCH];
    ch_state_t     st_d  [NCH];
    logic [W-1:0]  y1_q  [NCH];
    logic [W-1:0]  y1_d  [NCH];
    logic [W-1:0]  y2_q  [NCH];
    logic [W-1:0]  y2_d  [NCH];
    logic [W-1:0]  a_q   [NCH];
    logic [W-1:0]  a_d   [NCH];
    logic [W-1:0]  sh1_q [NCH];
    logic [W-1:0]  sh1_d [NCH];
    logic [W-1:0]  sh2_q [NCH];
    logic [W-1:0]  sh2_d [NCH];

    logic [CW-1:0] ptr_q, ptr_d;
    logic          smp_valid_q, smp_valid_d;
    logic [CW-1:0] smp_ch_q, smp_ch_d;
    logic [W-1:0]  smp_y_q, smp_y_d;

    logic [W-1:0]   cur_y1, cur_y2, cur_a;
    logic [2*W-1:0] prod;
    logic           prod_unused;
    logic [W-1:0]   y_new;
    logic           zero_cross;
    logic           xfer, hit, comp, reload;
    logic [W-1:0]   y_out;

    // Operands of the channel under the pointer.
    assign cur_y1 = y1_q[ptr_q];
    assign cur_y2 = y2_q[ptr_q];
    assign cur_a  = a_q[ptr_q];

    // Full signed product via explicit sign extension; only the middle W bits
    // (the Q-format realignment) feed the recurrence, the rest is discarded.
    assign prod        = {{W{cur_a[W-1]}}, cur_a} * {{W{cur_y1[W-1]}}, cur_y1};
    assign prod_unused = ^{prod[2*W-1:FRAC+W], prod[FRAC-1:0]};
    assign y_new       = prod[FRAC+W-1:FRAC] - cur_y2;

    // Near zero when the top ZCB bits are pure sign extension.
    assign zero_cross = (&cur_y1[W-1 -: ZCB]) | ~(|cur_y1[W-1 -: ZCB]);

    // A pending channel refuses everything, stop included, until it reloads.
    assign bus.Cfg_ready = (st_q[bus.Cfg_ch] != ST_PEND);
    assign xfer          = bus.Cfg_valid & bus.Cfg_ready;
    // A config landing on the channel being computed overrides the computation.
    assign hit           = xfer && (bus.Cfg_ch == ptr_q);
    assign comp          = Enable && (st_q[ptr_q] != ST_OFF) && !hit;
    assign reload        = comp && (st_q[ptr_q] == ST_PEND) && zero_cross;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            st_d[k]  = st_q[k];
            y1_d[k]  = y1_q[k];
            y2_d[k]  = y2_q[k];
            a_d[k]   = a_q[k];
            sh1_d[k] = sh1_q[k];
            sh2_d[k] = sh2_q[k];
        end
        ptr_d       = ptr_q;
        smp_valid_d = comp;
        smp_ch_d    = smp_ch_q;
        smp_y_d     = smp_y_q;
        y_out       = y_new;

        if (comp) begin
            if (reload) begin
                // Restart with a sign that continues the swing: if the wave
                // was coming down from positive (y2 >= 0) start negative.
                y_out             = cur_y2[W-1] ? sh1_q[ptr_q] : -sh1_q[ptr_q];
                y2_d[ptr_q]       = '0;
                a_d[ptr_q]        = sh2_q[ptr_q];
                st_d[ptr_q]       = ST_RUN;
            end else begin
                y2_d[ptr_q]       = cur_y1;
            end
            y1_d[ptr_q] = y_out;
            smp_ch_d    = ptr_q;
            smp_y_d     = y_out;
        end

        if (xfer) begin
            if (bus.Cfg_stop) begin
                st_d[bus.Cfg_ch]  = ST_OFF;
                y1_d[bus.Cfg_ch]  = '0;
                y2_d[bus.Cfg_ch]  = '0;
                sh1_d[bus.Cfg_ch] = '0;
                sh2_d[bus.Cfg_ch] = '0;
            end else if (!bus.Cfg_defer || st_q[bus.Cfg_ch] == ST_OFF) begin
                st_d[bus.Cfg_ch]  = ST_RUN;
                y1_d[bus.Cfg_ch]  = bus.Cfg_init1;
                y2_d[bus.Cfg_ch]  = '0;
                a_d[bus.Cfg_ch]   = bus.Cfg_init2;
            end else begin
                st_d[bus.Cfg_ch]  = ST_PEND;
                sh1_d[bus.Cfg_ch] = bus.Cfg_init1;
                sh2_d[bus.Cfg_ch] = bus.Cfg_init2;
            end
        end

        if (Enable) begin
            ptr_d = ptr_q + CW'(1);
        end
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < NCH; k++) begin
                st_q[k]  <= ST_OFF;
                y1_q[k]  <= '0;
                y2_q[k]  <= '0;
                a_q[k]   <= '0;
                sh1_q[k] <= '0;
                sh2_q[k] <= '0;
            end
            ptr_q       <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_y_q     <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                st_q[k]  <= st_d[k];
                y1_q[k]  <= y1_d[k];
                y2_q[k]  <= y2_d[k];
                a_q[k]   <= a_d[k];
                sh1_q[k] <= sh1_d[k];
                sh2_q[k] <= sh2_d[k];
            end
            ptr_q       <= ptr_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_y_q     <= smp_y_d;
        end
    end

    assign bus.Smp_valid = smp_valid_q;
    assign bus.Smp_ch    = smp_ch_q;
    assign bus.Smp_y     = smp_y_q;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            Active[k] = (st_q[k] != ST_OFF);
            Pend[k]   = (st_q[k] == ST_PEND);
        end
    end
endmodule

// File: tb/tb_osc_bank.sv
// tb/tb_osc_bank.sv - self-checking bench for osc_bank against a behavioural channel model
module tb_osc_bank;
    localparam int W    = 32;
    localparam int FRAC = 29;
    localparam int NCH  = 4;
    localparam int ZCB  = 10;
    localparam int OFF  = 0;
    localparam int RUN  = 1;
    localparam int PND  = 2;

    logic           Fg_clk = 1'b0;
    logic           Resetn;
    logic           Enable;
    logic [NCH-1:0] Active;
    logic [NCH-1:0] Pend;

    osc_bank_if #(.W(W), .NCH(NCH)) bus ();

    osc_bank #(.W(W), .FRAC(FRAC), .NCH(NCH), .ZCB(ZCB)) dut (
        .Fg_clk (Fg_clk),
        .Resetn (Resetn),
        .Enable (Enable),
        .bus    (bus),
        .Active (Active),
        .Pend   (Pend)
    );

    always #5 Fg_clk = ~Fg_clk;

    int          n_cmp = 0;
    int          n_err = 0;

    int          m_st [NCH];
    logic [31:0] m_y1 [NCH];
    logic [31:0] m_y2 [NCH];
    logic [31:0] m_a  [NCH];
    logic [31:0] m_s1 [NCH];
    logic [31:0] m_s2 [NCH];
    int          m_ptr;
    logic        exp_valid;
    logic [1:0]  exp_ch;
    logic [31:0] exp_y;

    function automatic bit is_zc(logic [31:0] v);
        int s;
        s = $signed(v) >>> (W - ZCB);
        return (s == 0) || (s == -1);
    endfunction

    function automatic logic [31:0] next_y(logic [31:0] a, logic [31:0] y1, logic [31:0] y2);
        longint p;
        p = longint'($signed(a)) * longint'($signed(y1));
        return 32'(p >>> FRAC) - y2;
    endfunction

    function automatic logic [NCH-1:0] exp_active();
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = (m_st[k] != OFF);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[k] = (m_st[k] == PND);
        return v;
    endfunction

    function automatic bit exp_ready(int ch);
        return m_st[ch] != PND;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_st[k] = OFF; m_y1[k] = 0; m_y2[k] = 0; m_a[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
        end
        m_ptr = 0; exp_valid = 0; exp_ch = 0; exp_y = 0;
    endtask

    task automatic drive_cfg(int ch, logic [31:0] i1, logic [31:0] i2, bit defer, bit stop);
        bus.Cfg_valid = 1'b1;
        bus.Cfg_ch    = 2'(ch);
        bus.Cfg_init1 = i1;
        bus.Cfg_init2 = i2;
        bus.Cfg_defer = defer;
        bus.Cfg_stop  = stop;
    endtask

    task automatic idle_cfg();
        bus.Cfg_valid = 1'b0;
        bus.Cfg_defer = 1'b0;
        bus.Cfg_stop  = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then
    // advance the DUT and leave time 1 unit past the edge.
    task automatic step();
        int k, c;
        bit xfer, comp;
        logic [31:0] yo;
        k    = m_ptr;
        c    = int'(bus.Cfg_ch);
        xfer = bus.Cfg_valid && exp_ready(c);
        comp = Enable && (m_st[k] != OFF) && !(xfer && c == k);
        if (comp) begin
            if (m_st[k] == PND && is_zc(m_y1[k])) begin
                yo = m_y2[k][31] ? m_s1[k] : -m_s1[k];
                m_y2[k] = 0; m_a[k] = m_s2[k]; m_st[k] = RUN;
            end else begin
                yo = next_y(m_a[k], m_y1[k], m_y2[k]);
                m_y2[k] = m_y1[k];
            end
            m_y1[k] = yo; exp_ch = 2'(k); exp_y = yo;
        end
        exp_valid = comp;
        if (xfer) begin
            if (bus.Cfg_stop) begin
                m_st[c] = OFF; m_y1[c] = 0; m_y2[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
            end else if (!bus.Cfg_defer || m_st[c] == OFF) begin
                m_st[c] = RUN; m_y1[c] = bus.Cfg_init1; m_y2[c] = 0; m_a[c] = bus.Cfg_init2;
            end else begin
                m_st[c] = PND; m_s1[c] = bus.Cfg_init1; m_s2[c] = bus.Cfg_init2;
            end
        end
        if (Enable) m_ptr = (m_ptr + 1) % NCH;
        @(posedge Fg_clk); #1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Enable = 1'b0; idle_cfg();
        bus.Cfg_ch = 0; bus.Cfg_init1 = 0; bus.Cfg_init2 = 0;
        model_reset();
        repeat (3) @(posedge Fg_clk);
        #1;
        n_cmp++; if (bus.Smp_valid !== 1'b0) begin n_err++; $display("FAIL reset_smp_valid got %b want 0", bus.Smp_valid); end
        n_cmp++; if (bus.Smp_ch !== 2'd0) begin n_err++; $display("FAIL reset_smp_ch got %0d want 0", bus.Smp_ch); end
        n_cmp++; if (bus.Smp_y !== 32'd0) begin n_err++; $display("FAIL reset_smp_y got %h want 0", bus.Smp_y); end
        n_cmp++; if (Active !== 4'b0) begin n_err++; $display("FAIL reset_active got %b want 0000", Active); end
        n_cmp++; if (Pend !== 4'b0) begin n_err++; $display("FAIL reset_pend got %b want 0000", Pend); end
        n_cmp++; if (bus.Cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", bus.Cfg_ready); end
        Resetn = 1'b1;
        step();
    endtask

    task automatic test_immediate();
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic [31:0] w0[3];
        logic [31:0] w1[4];
        w0 = '{32'h200, 32'h300, 32'h400};
        w1 = '{32'h0, 32'hFFFF_FF00, 32'h0, 32'h100};
        Enable = 1'b0;
        drive_cfg(0, 32'h100, 32'h4000_0000, 0, 0); step();
        drive_cfg(1, 32'h100, 32'h0, 0, 0); step();
        idle_cfg();
        n_cmp++; if (Active !== 4'b0011) begin n_err++; $display("FAIL imm_active got %b want 0011", Active); end
        Enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++;
            if ({bus.Smp_valid, bus.Smp_ch, bus.Smp_y} !== {exp_valid, exp_ch, exp_y}) begin
                n_err++;
                $display("FAIL imm_sample i=%0d got v=%b ch=%0d y=%h want v=%b ch=%0d y=%h",
                         i, bus.Smp_valid, bus.Smp_ch, bus.Smp_y, exp_valid, exp_ch, exp_y);
            end
            if (bus.Smp_valid === 1'b1 && bus.Smp_ch === 2'd0) q0.push_back(bus.Smp_y);
            if (bus.Smp_valid === 1'b1 && bus.Smp_ch === 2'd1) q1.push_back(bus.Smp_y);
        end
        n_cmp++;
        if (q0.size() < 3 || q1.size() < 4) begin
            n_err++; $display("FAIL imm_count got ch0=%0d ch1=%0d want >=3 >=4", q0.size(), q1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (q0[i] !== w0[i]) begin n_err++; $display("FAIL imm_ch0 idx=%0d got %h want %h", i, q0[i], w0[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (q1[i] !== w1[i]) begin n_err++; $display("FAIL imm_ch1 idx=%0d got %h want %h", i, q1[i], w1[i]); end
            end
        end
    endtask

    task automatic test_defer();
        logic [31:0] sh1, y2b;
        bit seen;
        int guard;
        Enable = 1'b1;
        drive_cfg(2, $urandom_range(2**27, 2**24), 32'h2000_0000, 0, 0); step(); idle_cfg();
        for (int r = 0; r < 2; r++) begin
            guard = 0;
            while ((m_st[2] != RUN || is_zc(m_y1[2])) && guard < 50) begin step(); guard++; end
            n_cmp++; if (guard >= 50) begin n_err++; $display("FAIL defer_wait_large round=%0d got timeout want large y1", r); end
            sh1 = $urandom_range(2**26, 2**23);
            drive_cfg(2, sh1, 32'h2000_0000, 1, 0);
            #1;
            n_cmp++; if (bus.Cfg_ready !== 1'b1) begin n_err++; $display("FAIL defer_ready_before got %b want 1", bus.Cfg_ready); end
            step(); idle_cfg();
            n_cmp++; if (Pend[2] !== 1'b1 || Pend !== exp_pend()) begin n_err++; $display("FAIL defer_pend_set got %b want %b", Pend, exp_pend()); end
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                drive_cfg(2, $urandom, $urandom, 0, 1);
                #1;
                n_cmp++; if (bus.Cfg_ready !== 1'b0) begin n_err++; $display("FAIL defer_ready_blocked i=%0d got %b want 0", i, bus.Cfg_ready); end
                y2b = m_y2[2];
                step(); idle_cfg();
                n_cmp++;
                if ({bus.Smp_valid, bus.Smp_ch, bus.Smp_y} !== {exp_valid, exp_ch, exp_y}) begin
                    n_err++;
                    $display("FAIL defer_sample i=%0d got v=%b ch=%0d y=%h want v=%b ch=%0d y=%h",
                             i, bus.Smp_valid, bus.Smp_ch, bus.Smp_y, exp_valid, exp_ch, exp_y);
                end
                if (exp_valid && exp_ch == 2'd2 && m_st[2] == RUN) begin
                    seen = 1;
                    n_cmp++;
                    if (bus.Smp_y !== (y2b[31] ? sh1 : -sh1) || Pend[2] !== 1'b0) begin
                        n_err++; $display("FAIL defer_reload got y=%h pend=%b want y=%h pend=0",
                                          bus.Smp_y, Pend[2], y2b[31] ? sh1 : -sh1);
                    end
                end
            end
            n_cmp++; if (!seen) begin n_err++; $display("FAIL defer_reload_timeout round=%0d got none want reload", r); end
        end
    endtask

    task automatic test_collision();
        logic [31:0] i1, i2, want;
        int guard;
        bit seen;
        Enable = 1'b1;
        drive_cfg(3, $urandom_range(2**20, 1), 32'h3000_0000, 0, 0); step(); idle_cfg();
        repeat (6) step();
        guard = 0;
        while (m_ptr != 3 && guard < 8) begin step(); guard++; end
        i1 = $urandom_range(2**24, 1);
        i2 = $urandom;
        drive_cfg(3, i1, i2, 0, 0);
        step(); idle_cfg();
        n_cmp++; if (bus.Smp_valid !== 1'b0 || exp_valid !== 1'b0) begin n_err++; $display("FAIL coll_dropped got %b want 0", bus.Smp_valid); end
        want = next_y(i2, i1, 32'd0);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (exp_valid && exp_ch == 2'd3) begin
                seen = 1;
                n_cmp++;
                if (bus.Smp_valid !== 1'b1 || bus.Smp_ch !== 2'd3 || bus.Smp_y !== want) begin
                    n_err++; $display("FAIL coll_new_init got v=%b ch=%0d y=%h want v=1 ch=3 y=%h",
                                      bus.Smp_valid, bus.Smp_ch, bus.Smp_y, want);
                end
            end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL coll_timeout got none want ch3 sample"); end
    endtask

    task automatic test_enable_gap();
        Enable = 1'b1;
        repeat (3) step();
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (bus.Smp_valid !== 1'b0) begin n_err++; $display("FAIL gap_valid i=%0d got %b want 0", i, bus.Smp_valid); end
        end
        Enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({bus.Smp_valid, bus.Smp_ch, bus.Smp_y} !== {exp_valid, exp_ch, exp_y}) begin
                n_err++;
                $display("FAIL gap_resume i=%0d got v=%b ch=%0d y=%h want v=%b ch=%0d y=%h",
                         i, bus.Smp_valid, bus.Smp_ch, bus.Smp_y, exp_valid, exp_ch, exp_y);
            end
        end
    endtask

    task automatic test_random();
        int ch;
        for (int i = 0; i < 400; i++) begin
            Enable = ($urandom_range(99, 0) < 85);
            ch = $urandom_range(NCH - 1, 0);
            if ($urandom_range(99, 0) < 30)
                drive_cfg(ch, $urandom, $urandom, $urandom_range(99, 0) < 40, $urandom_range(99, 0) < 10);
            else begin
                idle_cfg(); bus.Cfg_ch = 2'(ch);
            end
            #1;
            n_cmp++; if (bus.Cfg_ready !== exp_ready(ch)) begin n_err++; $display("FAIL rnd_ready i=%0d got %b want %b", i, bus.Cfg_ready, exp_ready(ch)); end
            step();
            n_cmp++;
            if ({bus.Smp_valid, bus.Smp_ch, bus.Smp_y, Active, Pend} !== {exp_valid, exp_ch, exp_y, exp_active(), exp_pend()}) begin
                n_err++;
                $display("FAIL rnd_state i=%0d got v=%b ch=%0d y=%h act=%b pend=%b want v=%b ch=%0d y=%h act=%b pend=%b",
                         i, bus.Smp_valid, bus.Smp_ch, bus.Smp_y, Active, Pend,
                         exp_valid, exp_ch, exp_y, exp_active(), exp_pend());
            end
        end
        idle_cfg();
    endtask

    task automatic test_reset_pend();
        Enable = 1'b0;
        drive_cfg(2, 32'h0100_0000, 32'h2000_0000, 0, 0); step();
        drive_cfg(2, 32'h0080_0000, 32'h2000_0000, 1, 0); step();
        idle_cfg();
        n_cmp++; if (Pend[2] !== 1'b1) begin n_err++; $display("FAIL rstp_setup got pend=%b want pend[2]=1", Pend); end
        #2 Resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.Smp_valid, bus.Smp_ch, bus.Smp_y, Active, Pend} !== '0) begin
            n_err++; $display("FAIL rstp_during got v=%b ch=%0d y=%h act=%b pend=%b want all 0",
                              bus.Smp_valid, bus.Smp_ch, bus.Smp_y, Active, Pend);
        end
        @(posedge Fg_clk); #1;
        Resetn = 1'b1;
        Enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if ({bus.Smp_valid, bus.Smp_ch, bus.Smp_y, Active, Pend} !== '0) begin
                n_err++; $display("FAIL rstp_after i=%0d got v=%b ch=%0d y=%h act=%b pend=%b want all 0",
                                  i, bus.Smp_valid, bus.Smp_ch, bus.Smp_y, Active, Pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_defer();
        test_collision();
        test_enable_gap();
        test_random();
        test_reset_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
